// File: rtl/score_pkg.sv
// Shared constants and helpers for the BCD score display: 7-segment font
// (active-high, {g,f,e,d,c,b,a}) and an MSD-first BCD magnitude compare.
package score_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_FONT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-decimal nibbles never light anything.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (nib <= 4'd9) seg = SEG_FONT[nib];
        return seg;
    endfunction

    // Operands are zero-extended to the widest supported score.
    function automatic logic bcd_gt(input logic [4*MAX_DIGITS-1:0] a,
                                    input logic [4*MAX_DIGITS-1:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!done) begin
                if (a[4*i +: 4] > b[4*i +: 4]) begin
                    gt   = 1'b1;
                    done = 1'b1;
                end else if (a[4*i +: 4] < b[4*i +: 4]) begin
                    done = 1'b1;
                end
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the score counter; carry_out is combinational so a whole
// chain of these ripples a single increment within one cycle.
module bcd_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_in,
    input  logic       clr,
    input  logic       hold,
    output logic [3:0] value,
    output logic       carry_out
);

    assign carry_out = inc_in && (value == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (inc_in && !hold) begin
            value <= (value >= 4'd9) ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/score_display.sv
// N-digit BCD score with multiplexed 7-segment scan, leading-zero blanking,
// wrap/saturate overflow and an optional high-score register (SCORE_HISCORE_EN).
module score_display
    import score_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 1,
    parameter int SATURATE    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    invert,
    input  logic                    inc,
    input  logic                    clr,
    input  logic                    blank_lz,
    input  logic                    show_hi,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digits,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [4*NUM_DIGITS-1:0] hi_bcd,
    output logic                    overflow,
    output logic                    new_hi
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [15:0]      PRE_LAST = 16'(REFRESH_DIV - 1);

    // carry[NUM_DIGITS] is high exactly when inc arrives at 10^N-1.
    logic [NUM_DIGITS:0] carry;
    logic                hold_all;

    assign carry[0] = inc;
    assign hold_all = (SATURATE != 0) && carry[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_in    (carry[i]),
            .clr       (clr),
            .hold      (hold_all),
            .value     (score_bcd[4*i +: 4]),
            .carry_out (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else        overflow <= carry[NUM_DIGITS] && !clr;
    end

`ifdef SCORE_HISCORE_EN
    logic [W-1:0] hi_q;
    logic         new_hi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            new_hi_q <= 1'b0;
        end else if (clr && bcd_gt(32'(score_bcd), 32'(hi_q))) begin
            hi_q     <= score_bcd;
            new_hi_q <= 1'b1;
        end else begin
            new_hi_q <= 1'b0;
        end
    end

    assign hi_bcd = hi_q;
    assign new_hi = new_hi_q;
`else
    logic unused_show_hi;
    assign unused_show_hi = show_hi;
    assign hi_bcd         = '0;
    assign new_hi         = 1'b0;
`endif

    logic [15:0]      prescale;
    logic [IDX_W-1:0] idx;
    logic             terminal;

    assign terminal = (prescale == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= 16'd0;
            idx      <= '0;
        end else begin
            prescale <= terminal ? 16'd0 : prescale + 16'd1;
            if (terminal) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    logic [W-1:0]            shown;
    logic [3:0]              nib;
    logic                    zero_above;
    logic                    blank;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   dig_next;

`ifdef SCORE_HISCORE_EN
    assign shown = show_hi ? hi_bcd : score_bcd;
`else
    assign shown = score_bcd;
`endif

    // A digit is a leading zero when it and every more significant nibble are 0.
    always_comb begin
        nib        = 4'd0;
        zero_above = 1'b1;
        dig_next   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_next[i] = (idx == IDX_W'(i));
            if (idx == IDX_W'(i)) nib = shown[4*i +: 4];
            if ((IDX_W'(i) >= idx) && (shown[4*i +: 4] != 4'd0)) zero_above = 1'b0;
        end
        blank    = blank_lz && (idx != '0) && zero_above;
        seg_next = (ena && !blank) ? bcd_to_seg(nib) : SEG_BLANK;
    end

    logic [6:0]            raw_seg;
    logic [NUM_DIGITS-1:0] raw_dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_seg <= SEG_BLANK;
            raw_dig <= '0;
        end else begin
            raw_seg <= seg_next;
            raw_dig <= dig_next;
        end
    end

    assign segments = raw_seg ^ {7{invert}};
    assign digits   = raw_dig ^ {NUM_DIGITS{invert}};

endmodule
